j1708_tx_access_ctrl: RTL and testbench
=======================================

Name: j1708_tx_access_ctrl

Overview:
Sequences J1708 transmit requests onto the shared J1708 bus. It latches a request from the register bank (length, priority, new-message pulse) and waits for the priority-dependent bus access time. It then starts the byte serializer, monitors for collision, and retries with a bounded count. It drives the TX-ready status bit read back through the register bank and raises an error pulse for the interrupt logic.

Parameters:
BIT_TICKS, 2500, clk cycles per J1708 bit time (24 MHz / 9600 baud); minimum 2
MAX_RETRIES, 7, collision retries before abort (1..15)
IDLE_BASE_BITS, 12, bus idle bit times required at priority field 0 (J1708 priority 1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
enable  input  1  J1708 enable from control register; low aborts and holds IDLE
tx_new  input  1  single-cycle request pulse
tx_len  input  8  message length in bytes including MID and checksum
tx_prio  input  3  priority field 0..7 (J1708 priority 1..8)
bus_rx  input  1  synchronized bus level; 1 = recessive/idle
ser_start  output  1  single-cycle start pulse to byte serializer
ser_len  output  8  latched length presented to serializer, stable from ser_start until ser_busy falls
ser_busy  input  1  serializer transmitting
ser_collision  input  1  single-cycle pulse; serializer echo mismatch, serializer has stopped
tx_ready  output  1  1 = ready for new request (register bit 31)
tx_error  output  1  single-cycle pulse; retries exhausted
tx_overrun  output  1  single-cycle pulse; tx_new while not ready or disabled
bus_idle_bits  output  5  saturating count of consecutive idle bit times (debug/status)

Behaviour:
- Reset (rst_n low, async): state IDLE. tx_ready=1. ser_start=0, tx_error=0, tx_overrun=0, ser_len=0, retry count=0, bus_idle_bits=0.
- Idle timer:
  - The tick counter runs while bus_rx=1.
  - Any cycle with bus_rx=0 clears the tick counter and bus_idle_bits in the next cycle.
  - bus_idle_bits increments when the tick counter wraps at BIT_TICKS-1, saturating at 31.
- Access threshold = IDLE_BASE_BITS + 2*tx_prio, using latched prio. Range 12..26; computed 5-bit, no overflow.
- States:
  - IDLE:
    - tx_new & enable & tx_ready: latch len/prio, clear retries, tx_ready<=0, go WAIT_ACCESS.
    - tx_new with tx_len=0: tx_ready stays 1, no start, tx_overrun pulses.
  - WAIT_ACCESS:
    - When bus_idle_bits >= threshold, ser_start pulses the next cycle and the state moves to SEND.
    - The bus going busy resets waiting implicitly through the timer.
  - SEND:
    - ser_collision: go BACKOFF. If retries==MAX_RETRIES, go IDLE instead with tx_error pulse and tx_ready<=1.
    - ser_busy falling with no collision: go IDLE, tx_ready<=1.
  - BACKOFF: increment retries, go WAIT_ACCESS. The timer restarts naturally because the collision drove bus_rx low.
- Latency: threshold met in cycle N gives ser_start in cycle N+1. Successful completion gives tx_ready=1 one cycle after ser_busy falls.
- tx_new while tx_ready=0 or enable=0: ignored, tx_overrun pulses next cycle, latched fields unchanged.
- enable falling in any state: next cycle IDLE, tx_ready=1, no tx_error, ser_start suppressed. An in-flight serializer frame is not aborted by this block.
- ser_collision and ser_busy falling in the same cycle: collision wins.
- ser_collision outside SEND: ignored.
- Reset mid-SEND: immediate IDLE; serializer is reset by the same rst_n.

Decomposition:
- Package j1708_pkg: state enumeration (IDLE, WAIT_ACCESS, SEND, BACKOFF), IDLE_BASE_BITS, PRIO_STEP_BITS=2, IDLE_CNT_W=5, default BIT_TICKS.
- One sub-module j1708_idle_timer (clk, rst_n, bus_rx → bus_idle_bits), reused by the RX framer for end-of-message detection.

Test Plan:
All scenarios use BIT_TICKS=4.
1. bus_rx=1 constant, tx_new with prio=0, len=5 → ser_start exactly 12*4 cycles after timer start; ser_len=5; tx_ready=0 until ser_busy falls, then 1 one cycle later.
2. prio=7 → ser_start after 26 bit times (104 cycles). bus_rx=0 pulse at bit 20 → timer restarts; ser_start 26 bit times after the pulse ends.
3. Collision on each attempt with MAX_RETRIES=2 → 3 ser_start pulses, then one tx_error pulse, tx_ready=1, state IDLE.
4. tx_new during SEND → tx_overrun pulse, ser_len unchanged, the transmission completes normally.
5. enable deasserted in WAIT_ACCESS → tx_ready=1 next cycle, no ser_start, no tx_error.
6. ser_collision coincident with ser_busy fall → retry taken (BACKOFF); rst_n low mid-WAIT_ACCESS → tx_ready=1 asynchronously, bus_idle_bits=0.

Source files
------------

// File: rtl/j1708_pkg.sv
// Shared types and constants for the J1708 transmit path.
package j1708_pkg;

  localparam int unsigned BIT_TICKS_DEF      = 2500;
  localparam int unsigned IDLE_BASE_BITS_DEF = 12;
  localparam int unsigned PRIO_STEP_BITS     = 2;
  localparam int unsigned IDLE_CNT_W         = 5;
  localparam int unsigned IDLE_CNT_MAX       = (1 << IDLE_CNT_W) - 1;
  localparam int unsigned LEN_W              = 8;
  localparam int unsigned PRIO_W             = 3;
  localparam int unsigned RETRY_W            = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACCESS,
    SEND,
    BACKOFF
  } state_e;

  // Idle bit times required before this priority may take the bus.
  function automatic logic [IDLE_CNT_W-1:0] access_threshold(input int unsigned base,
                                                             input logic [PRIO_W-1:0] prio);
    return IDLE_CNT_W'(base + PRIO_STEP_BITS * 32'(prio));
  endfunction

endpackage

// File: rtl/j1708_tx_access_ctrl_if.sv
// Handshake between the bus access controller and the byte serializer.
interface j1708_tx_access_ctrl_if;
  import j1708_pkg::*;

  logic             ser_start;
  logic [LEN_W-1:0] ser_len;
  logic             ser_busy;
  logic             ser_collision;

  modport master (output ser_start, output ser_len, input ser_busy, input ser_collision);
  modport slave  (input ser_start, input ser_len, output ser_busy, output ser_collision);
endinterface

// File: rtl/j1708_idle_timer.sv
// Counts consecutive idle bit times on the J1708 bus, saturating; any low sample restarts it.
module j1708_idle_timer
  import j1708_pkg::*;
#(
  parameter int unsigned BIT_TICKS = BIT_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_rx,
  output logic [IDLE_CNT_W-1:0] bus_idle_bits
);

  localparam int unsigned TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  logic [TICK_W-1:0]     r_tick;
  logic [IDLE_CNT_W-1:0] r_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_bits <= '0;
    end else if (!bus_rx) begin
      r_tick <= '0;
      r_bits <= '0;
    end else if (r_tick == TICK_W'(BIT_TICKS - 1)) begin
      r_tick <= '0;
      if (r_bits != IDLE_CNT_W'(IDLE_CNT_MAX)) r_bits <= r_bits + IDLE_CNT_W'(1);
    end else begin
      r_tick <= r_tick + TICK_W'(1);
    end
  end

  assign bus_idle_bits = r_bits;

endmodule

// File: rtl/j1708_tx_access_ctrl.sv
// J1708 transmit access control: waits for priority-dependent idle time, starts the
// serializer, and retries on collision up to MAX_RETRIES times.
module j1708_tx_access_ctrl
  import j1708_pkg::*;
#(
  parameter int unsigned BIT_TICKS      = BIT_TICKS_DEF,
  parameter int unsigned MAX_RETRIES    = 7,
  parameter int unsigned IDLE_BASE_BITS = IDLE_BASE_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  tx_new,
  input  logic [LEN_W-1:0]      tx_len,
  input  logic [PRIO_W-1:0]     tx_prio,
  input  logic                  bus_rx,
  j1708_tx_access_ctrl_if.master ser,
  output logic                  tx_ready,
  output logic                  tx_error,
  output logic                  tx_overrun,
  output logic [IDLE_CNT_W-1:0] bus_idle_bits
);

  state_e                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [PRIO_W-1:0]     r_prio;
  logic [RETRY_W-1:0]    r_retries;
  logic                  r_ser_start;
  logic                  r_tx_ready;
  logic                  r_tx_error;
  logic                  r_tx_overrun;
  logic                  r_busy_q;

  logic [IDLE_CNT_W-1:0] w_idle_bits;
  logic [IDLE_CNT_W-1:0] w_threshold;
  logic                  w_accept;
  logic                  w_busy_fell;

  j1708_idle_timer #(.BIT_TICKS(BIT_TICKS)) u_idle_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_rx        (bus_rx),
    .bus_idle_bits (w_idle_bits)
  );

  assign w_threshold = access_threshold(IDLE_BASE_BITS, r_prio);
  assign w_accept    = tx_new & enable & r_tx_ready & (r_state == IDLE) & (tx_len != '0);
  assign w_busy_fell = r_busy_q & ~ser.ser_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_prio       <= '0;
      r_retries    <= '0;
      r_ser_start  <= 1'b0;
      r_tx_ready   <= 1'b1;
      r_tx_error   <= 1'b0;
      r_tx_overrun <= 1'b0;
      r_busy_q     <= 1'b0;
    end else begin
      r_ser_start  <= 1'b0;
      r_tx_error   <= 1'b0;
      r_tx_overrun <= tx_new & ~w_accept;
      r_busy_q     <= ser.ser_busy;
      // Disable abandons the request; a frame already on the wire finishes by itself.
      if (!enable) begin
        r_state    <= IDLE;
        r_tx_ready <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_len      <= tx_len;
              r_prio     <= tx_prio;
              r_retries  <= '0;
              r_tx_ready <= 1'b0;
              r_state    <= WAIT_ACCESS;
            end
          end
          WAIT_ACCESS: begin
            if (w_idle_bits >= w_threshold) begin
              r_ser_start <= 1'b1;
              r_state     <= SEND;
            end
          end
          SEND: begin
            // Collision takes precedence over a simultaneous busy fall.
            if (ser.ser_collision) begin
              if (r_retries == RETRY_W'(MAX_RETRIES)) begin
                r_tx_error <= 1'b1;
                r_tx_ready <= 1'b1;
                r_state    <= IDLE;
              end else begin
                r_state <= BACKOFF;
              end
            end else if (w_busy_fell) begin
              r_tx_ready <= 1'b1;
              r_state    <= IDLE;
            end
          end
          BACKOFF: begin
            r_retries <= r_retries + RETRY_W'(1);
            r_state   <= WAIT_ACCESS;
          end
          default: begin
            r_tx_ready <= 1'b1;
            r_state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign ser.ser_start = r_ser_start;
  assign ser.ser_len   = r_len;
  assign tx_ready      = r_tx_ready;
  assign tx_error      = r_tx_error;
  assign tx_overrun    = r_tx_overrun;
  assign bus_idle_bits = w_idle_bits;

endmodule

// File: tb/tb_j1708_tx_access_ctrl.sv
// Bench for j1708_tx_access_ctrl with BIT_TICKS=4, MAX_RETRIES=2; starts are scoreboarded.
module tb_j1708_tx_access_ctrl;
  import j1708_pkg::*;

  localparam int unsigned BT   = 4;
  localparam int unsigned MAXR = 2;

  logic       clk = 1'b0;
  logic       rst_n, enable, tx_new, bus_rx;
  logic [7:0] tx_len;
  logic [2:0] tx_prio;
  logic       tx_ready, tx_error, tx_overrun;
  logic [4:0] bus_idle_bits;

  j1708_tx_access_ctrl_if ser_if();

  j1708_tx_access_ctrl #(.BIT_TICKS(BT), .MAX_RETRIES(MAXR), .IDLE_BASE_BITS(12)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .tx_new        (tx_new),
    .tx_len        (tx_len),
    .tx_prio       (tx_prio),
    .bus_rx        (bus_rx),
    .ser           (ser_if),
    .tx_ready      (tx_ready),
    .tx_error      (tx_error),
    .tx_overrun    (tx_overrun),
    .bus_idle_bits (bus_idle_bits)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, n_start = 0, n_err = 0, rel_cyc = 0;

  typedef struct { logic [7:0] len; int at; int bits; } exp_t;
  exp_t q[$];

  typedef struct { logic [2:0] prio; logic [7:0] len; int bits; } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every start pulse is matched against the oldest expected start.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (tx_error) n_err++;
    if (ser_if.ser_start) begin
      n_start++;
      if (q.size() == 0) begin
        chk("unexpected_ser_start", 1, 0);
      end else begin
        e = q.pop_front();
        chk("start_cycle", cyc, e.at);
        chk("ser_len_at_start", 32'(ser_if.ser_len), 32'(e.len));
        chk("idle_bits_at_start", 32'(bus_idle_bits), e.bits);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic clear_bus();
    bus_rx = 1'b0;
    step();
  endtask

  task automatic request(input logic [2:0] p, input logic [7:0] l);
    bus_rx  = 1'b1;
    rel_cyc = cyc;
    tx_prio = p;
    tx_len  = l;
    tx_new  = 1'b1;
    step();
    tx_new  = 1'b0;
  endtask

  // Timer counts from the first edge that samples the bus idle.
  task automatic push_exp(input logic [7:0] l, input int bits);
    exp_t e;
    e.len  = l;
    e.at   = rel_cyc + 1 + bits * int'(BT);
    e.bits = bits;
    q.push_back(e);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!ser_if.ser_start && n < 400) begin
      step();
      n++;
    end
    chk(name, 32'(ser_if.ser_start), 1);
  endtask

  task automatic serve_ok(input logic [7:0] len, input bit inject);
    ser_if.ser_busy = 1'b1;
    bus_rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (inject && i == 1) begin
        tx_new  = 1'b1;
        tx_len  = 8'd77;
        tx_prio = 3'd5;
      end
      step();
      if (inject && i == 1) begin
        tx_new = 1'b0;
        chk("overrun_in_send", 32'(tx_overrun), 1);
      end
      chk("ready_while_busy", 32'(tx_ready), 0);
      chk("ser_len_hold", 32'(ser_if.ser_len), 32'(len));
    end
    ser_if.ser_busy = 1'b0;
    bus_rx  = 1'b1;
    rel_cyc = cyc;
    step();
    chk("ready_after_busy_fall", 32'(tx_ready), 1);
  endtask

  task automatic collide(input bit coincident);
    ser_if.ser_busy = 1'b1;
    bus_rx = 1'b0;
    step_n(2);
    ser_if.ser_collision = 1'b1;
    if (coincident) ser_if.ser_busy = 1'b0;
    step();
    ser_if.ser_collision = 1'b0;
    ser_if.ser_busy = 1'b0;
    bus_rx  = 1'b1;
    rel_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int   s0, e0;
    tbl[0] = '{prio: 3'd0, len: 8'd5,  bits: 12};
    tbl[1] = '{prio: 3'd7, len: 8'd9,  bits: 26};
    tbl[2] = '{prio: 3'd3, len: 8'd21, bits: 18};
    tbl[3] = '{prio: 3'd1, len: 8'd1,  bits: 14};

    rst_n = 1'b0; enable = 1'b1; tx_new = 1'b0; tx_len = '0; tx_prio = '0; bus_rx = 1'b1;
    ser_if.ser_busy = 1'b0; ser_if.ser_collision = 1'b0;
    step_n(3);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_ser_start", 32'(ser_if.ser_start), 0);
    chk("rst_tx_error", 32'(tx_error), 0);
    chk("rst_tx_overrun", 32'(tx_overrun), 0);
    chk("rst_ser_len", 32'(ser_if.ser_len), 0);
    chk("rst_idle_bits", 32'(bus_idle_bits), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      clear_bus();
      request(tbl[i].prio, tbl[i].len);
      chk("ready_after_request", 32'(tx_ready), 0);
      push_exp(tbl[i].len, tbl[i].bits);
      wait_start("start_tbl");
      serve_ok(tbl[i].len, 1'b0);
    end

    // Bus activity at bit 20 restarts the priority-8 wait.
    clear_bus();
    request(3'd7, 8'd11);
    while (cyc < rel_cyc + 80) step();
    chk("idle_bits_at_20", 32'(bus_idle_bits), 20);
    bus_rx = 1'b0;
    step();
    chk("idle_bits_cleared", 32'(bus_idle_bits), 0);
    bus_rx  = 1'b1;
    rel_cyc = cyc;
    push_exp(8'd11, 26);
    wait_start("start_after_glitch");
    serve_ok(8'd11, 1'b0);

    // Collision on every attempt exhausts the retries.
    s0 = n_start; e0 = n_err;
    clear_bus();
    request(3'd0, 8'd3);
    push_exp(8'd3, 12);
    for (int a = 0; a < 3; a++) begin
      wait_start("start_retry");
      collide(1'b0);
      if (a < 2) begin
        chk("ready_in_backoff", 32'(tx_ready), 0);
        chk("no_error_in_backoff", 32'(tx_error), 0);
        push_exp(8'd3, 12);
      end else begin
        chk("error_pulse", 32'(tx_error), 1);
        chk("ready_after_abort", 32'(tx_ready), 1);
      end
    end
    step();
    chk("error_single_cycle", 32'(tx_error), 0);
    step_n(60);
    chk("error_pulse_count", n_err - e0, 1);
    chk("attempt_count", n_start - s0, 3);

    // Request during SEND is rejected without disturbing the frame.
    clear_bus();
    request(3'd2, 8'd40);
    push_exp(8'd40, 16);
    wait_start("start_overrun_case");
    serve_ok(8'd40, 1'b1);

    // Disable while waiting for access.
    clear_bus();
    request(3'd0, 8'd4);
    step_n(10);
    chk("ready_waiting", 32'(tx_ready), 0);
    s0 = n_start; e0 = n_err;
    enable = 1'b0;
    step();
    chk("ready_after_disable", 32'(tx_ready), 1);
    tx_new = 1'b1; tx_len = 8'd6;
    step();
    tx_new = 1'b0;
    chk("overrun_disabled", 32'(tx_overrun), 1);
    chk("ready_disabled", 32'(tx_ready), 1);
    step_n(60);
    chk("no_start_disabled", n_start, s0);
    chk("no_error_disabled", n_err, e0);
    enable = 1'b1;
    step_n(5);

    // Zero-length request is refused.
    tx_new = 1'b1; tx_len = 8'd0; tx_prio = 3'd0;
    step();
    tx_new = 1'b0;
    chk("overrun_len0", 32'(tx_overrun), 1);
    chk("ready_len0", 32'(tx_ready), 1);
    step();
    chk("overrun_single_cycle", 32'(tx_overrun), 0);
    step_n(60);

    // Collision and busy fall together: retry wins.
    clear_bus();
    request(3'd1, 8'd7);
    push_exp(8'd7, 14);
    wait_start("start_coincident");
    collide(1'b1);
    chk("ready_coincident", 32'(tx_ready), 0);
    step();
    chk("ready_coincident_backoff", 32'(tx_ready), 0);
    push_exp(8'd7, 14);
    wait_start("start_after_coincident");
    serve_ok(8'd7, 1'b0);

    // Asynchronous reset while waiting for access.
    clear_bus();
    request(3'd2, 8'd6);
    step_n(20);
    chk("idle_bits_before_reset", 32'(bus_idle_bits), 5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(tx_ready), 1);
    chk("async_rst_idle_bits", 32'(bus_idle_bits), 0);
    chk("async_rst_ser_len", 32'(ser_if.ser_len), 0);
    s0 = n_start;
    step_n(2);
    rst_n = 1'b1;
    step_n(120);
    chk("no_start_after_reset", n_start, s0);
    step_n(20);
    chk("idle_bits_saturate", 32'(bus_idle_bits), 31);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
